// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
// The arbiter uses the slave view; the requester/memory side uses master.
interface dmem_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              ack0;
  logic [DATA_W-1:0] rdata0;
  logic              err0;
  logic              stall0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              ack1;
  logic [DATA_W-1:0] rdata1;
  logic              err1;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  mem_read_data,
    output ack0, rdata0, err0, stall0,
    output ack1, rdata1, err1,
    output mem_read, mem_write, mem_address, mem_write_data
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output mem_read_data,
    input  ack0, rdata0, err0, stall0,
    input  ack1, rdata1, err1,
    input  mem_read, mem_write, mem_address, mem_write_data
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer for the word-addressed data memory:
// one request latched at a time, one memory cycle, one-cycle ack.
//
// state  | meaning
// IDLE   | sample requests, arbitrate, latch the granted request
// ACCESS | drive memory for exactly one cycle, capture read data
// RESP   | pulse ack/err/rdata on the granted port
module dmem_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 1024
) (
  input logic          clk,
  input logic          rst,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              id_q, id_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              in_range_q, in_range_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              grant;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              in_access;
  logic              in_resp;
  logic              ack0;
  logic              ack1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      in_range_q   <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      in_range_q   <= in_range_d;
      rdata_q      <= rdata_d;
    end
  end

  // On a tie the port not granted last wins; otherwise the lone requester.
  always_comb begin
    grant = (bus.req0 && bus.req1) ? ~last_grant_q : bus.req1;
    sel_we    = grant ? bus.we1    : bus.we0;
    sel_addr  = grant ? bus.addr1  : bus.addr0;
    sel_wdata = grant ? bus.wdata1 : bus.wdata0;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    in_range_d   = in_range_q;
    rdata_d      = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          id_d         = grant;
          last_grant_d = grant;
          we_d         = sel_we;
          addr_d       = sel_addr;
          wdata_d      = sel_wdata;
          in_range_d   = (sel_addr < DEPTH_A);
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        rdata_d = (!we_q && in_range_q) ? bus.mem_read_data : '0;
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_access = (state_q == ACCESS);
  assign in_resp   = (state_q == RESP);

  // Enables are gated by rst so an access cut short by reset never commits.
  assign bus.mem_read       = in_access && !we_q && in_range_q && !rst;
  assign bus.mem_write      = in_access &&  we_q && in_range_q && !rst;
  assign bus.mem_address    = addr_q;
  assign bus.mem_write_data = wdata_q;

  assign ack0 = in_resp && !id_q;
  assign ack1 = in_resp &&  id_q;

  assign bus.ack0   = ack0;
  assign bus.ack1   = ack1;
  assign bus.rdata0 = ack0 ? rdata_q : '0;
  assign bus.rdata1 = ack1 ? rdata_q : '0;
  assign bus.err0   = ack0 && !in_range_q;
  assign bus.err1   = ack1 && !in_range_q;
  assign bus.stall0 = bus.req0 && !ack0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and randomized bench for dmem_arbiter against a transaction-level
// model of arbitration order, latency and memory contents.
module tb_dmem_arbiter;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic preload = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] mem     [0:DEPTH-1];
  logic [31:0] ref_mem [0:DEPTH-1];
  int          last_g;
  logic        r_we   [2];
  logic [31:0] r_addr [2];
  logic [31:0] r_wd   [2];

  dmem_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  dmem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'(i);
    end else if (bus.mem_write && bus.mem_address < 32'(DEPTH)) begin
      mem[bus.mem_address[9:0]] <= bus.mem_write_data;
    end
  end

  assign bus.mem_read_data = (bus.mem_address < 32'(DEPTH)) ? mem[bus.mem_address[9:0]] : '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_rng(input int p);
    return r_addr[p] < 32'(DEPTH);
  endfunction

  task automatic apply_ports(input bit q0, input bit q1);
    bus.req0 = q0; bus.we0 = r_we[0]; bus.addr0 = r_addr[0]; bus.wdata0 = r_wd[0];
    bus.req1 = q1; bus.we1 = r_we[1]; bus.addr1 = r_addr[1]; bus.wdata1 = r_wd[1];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One arbitration round: either port alone, or both presented together.
  task automatic run_txn(input string name, input bit q0, input bit q1);
    bit          both;
    int          first, second, end_t, acc_p;
    int          exp_t [2];
    logic [31:0] exp_rd [2];
    logic        exp_err [2];
    bit          want [2];
    want[0] = q0; want[1] = q1;
    both   = q0 && q1;
    first  = both ? 1 - last_g : (q1 ? 1 : 0);
    second = 1 - first;
    exp_t[0] = -1; exp_t[1] = -1;
    exp_rd[0] = '0; exp_rd[1] = '0;
    exp_err[0] = 1'b0; exp_err[1] = 1'b0;
    exp_t[first] = 2;
    if (both) exp_t[second] = 5;
    for (int k = 0; k < (both ? 2 : 1); k++) begin
      int p;
      p = (k == 0) ? first : second;
      if (!in_rng(p)) begin
        exp_err[p] = 1'b1;
      end else if (r_we[p]) begin
        ref_mem[r_addr[p][9:0]] = r_wd[p];
      end else begin
        exp_rd[p] = ref_mem[r_addr[p][9:0]];
      end
    end
    last_g = both ? second : first;
    end_t  = both ? 6 : 3;
    apply_ports(q0, q1);
    for (int t = 0; t < end_t; t++) begin
      if (t > 0) @(posedge clk);
      #1;
      if (t > 0 && t == exp_t[0] + 1) bus.req0 = 1'b0;
      if (t > 0 && t == exp_t[1] + 1) bus.req1 = 1'b0;
      #1;
      acc_p = (t == 1) ? first : ((both && t == 4) ? second : -1);
      if (acc_p >= 0) begin
        chk($sformatf("%s t%0d mem_read", name, t), 32'(bus.mem_read), 32'(!r_we[acc_p] && in_rng(acc_p)));
        chk($sformatf("%s t%0d mem_write", name, t), 32'(bus.mem_write), 32'(r_we[acc_p] && in_rng(acc_p)));
        chk($sformatf("%s t%0d mem_address", name, t), bus.mem_address, r_addr[acc_p]);
        if (r_we[acc_p]) chk($sformatf("%s t%0d mem_wdata", name, t), bus.mem_write_data, r_wd[acc_p]);
      end else begin
        chk($sformatf("%s t%0d mem_en", name, t), {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
      end
      chk($sformatf("%s t%0d ack0", name, t), 32'(bus.ack0), 32'(t == exp_t[0]));
      chk($sformatf("%s t%0d ack1", name, t), 32'(bus.ack1), 32'(t == exp_t[1]));
      chk($sformatf("%s t%0d stall0", name, t), 32'(bus.stall0), 32'(want[0] && t < exp_t[0]));
      chk($sformatf("%s t%0d rdata0", name, t), bus.rdata0, (t == exp_t[0]) ? exp_rd[0] : 32'd0);
      chk($sformatf("%s t%0d rdata1", name, t), bus.rdata1, (t == exp_t[1]) ? exp_rd[1] : 32'd0);
      chk($sformatf("%s t%0d err0", name, t), 32'(bus.err0), 32'((t == exp_t[0]) && exp_err[0]));
      chk($sformatf("%s t%0d err1", name, t), 32'(bus.err1), 32'((t == exp_t[1]) && exp_err[1]));
    end
    tick();
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
  endtask

  task automatic set_port(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
    r_we[p] = we; r_addr[p] = a; r_wd[p] = d;
  endtask

  task automatic chk_quiet(input string name);
    chk({name, " ack"}, {30'd0, bus.ack0, bus.ack1}, 32'd0);
    chk({name, " err"}, {30'd0, bus.err0, bus.err1}, 32'd0);
    chk({name, " rdata0"}, bus.rdata0, 32'd0);
    chk({name, " rdata1"}, bus.rdata1, 32'd0);
    chk({name, " mem_en"}, {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
    chk({name, " mem_address"}, bus.mem_address, 32'd0);
    chk({name, " mem_wdata"}, bus.mem_write_data, 32'd0);
  endtask

  initial begin
    int ack_t [4];
    int ack_p [4];
    int lg;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'(i);
    for (int p = 0; p < 2; p++) set_port(p, 1'b0, 32'd0, 32'd0);
    apply_ports(1'b0, 1'b0);
    last_g = 1;

    repeat (3) tick();
    chk_quiet("reset");
    chk("reset stall0", 32'(bus.stall0), 32'd0);
    preload = 1'b0;
    rst = 1'b0;
    tick();

    set_port(0, 1'b0, 32'd7, 32'd0);
    run_txn("read7", 1'b1, 1'b0);

    set_port(1, 1'b1, 32'd12, 32'hDEADBEEF);
    run_txn("wr12", 1'b0, 1'b1);
    set_port(1, 1'b0, 32'd12, 32'd0);
    run_txn("rd12", 1'b0, 1'b1);

    set_port(0, 1'b1, 32'd1024, 32'h5555AAAA);
    run_txn("oor_wr", 1'b1, 1'b0);
    set_port(0, 1'b0, 32'hFFFFFFFF, 32'd0);
    run_txn("oor_rd", 1'b1, 1'b0);

    // Reset lands on the ACCESS cycle of a port 1 write.
    set_port(1, 1'b1, 32'd5, 32'h12345678);
    apply_ports(1'b0, 1'b1);
    tick();
    rst = 1'b1;
    #1;
    chk("rstmid mem_write", 32'(bus.mem_write), 32'd0);
    tick();
    chk_quiet("rstmid after");
    rst = 1'b0;
    bus.req1 = 1'b0;
    last_g = 1;
    tick();
    chk("rstmid mem5", mem[5], ref_mem[5]);
    chk("rstmid ack1", 32'(bus.ack1), 32'd0);

    // Both ports held continuously: grants alternate, one round every 3 cycles.
    set_port(0, 1'b0, 32'd3, 32'd0);
    set_port(1, 1'b0, 32'd4, 32'd0);
    lg = last_g;
    for (int k = 0; k < 4; k++) begin
      ack_p[k] = 1 - lg;
      ack_t[k] = 3 * k + 2;
      lg = ack_p[k];
    end
    last_g = lg;
    apply_ports(1'b1, 1'b1);
    for (int t = 0; t < 12; t++) begin
      bit e0, e1;
      if (t > 0) tick();
      e0 = 1'b0; e1 = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (ack_t[k] == t && ack_p[k] == 0) e0 = 1'b1;
        if (ack_t[k] == t && ack_p[k] == 1) e1 = 1'b1;
      end
      chk($sformatf("cont t%0d ack0", t), 32'(bus.ack0), 32'(e0));
      chk($sformatf("cont t%0d ack1", t), 32'(bus.ack1), 32'(e1));
      if (e0) chk($sformatf("cont t%0d rdata0", t), bus.rdata0, ref_mem[3]);
      if (e1) chk($sformatf("cont t%0d rdata1", t), bus.rdata1, ref_mem[4]);
    end
    tick();
    apply_ports(1'b0, 1'b0);
    tick();

    // Port 0 re-requests with a new address right after its ack.
    set_port(0, 1'b0, 32'd20, 32'd0);
    apply_ports(1'b1, 1'b0);
    for (int t = 0; t < 6; t++) begin
      if (t > 0) tick();
      if (t == 3) begin
        bus.addr0 = 32'd21;
        #1;
      end
      chk($sformatf("b2b t%0d ack0", t), 32'(bus.ack0), 32'(t == 2 || t == 5));
      if (t == 2) chk("b2b rdata first", bus.rdata0, ref_mem[20]);
      if (t == 5) chk("b2b rdata second", bus.rdata0, ref_mem[21]);
    end
    tick();
    apply_ports(1'b0, 1'b0);
    last_g = 0;

    for (int n = 0; n < 60; n++) begin
      int mode;
      mode = int'($urandom_range(0, 2));
      for (int p = 0; p < 2; p++) begin
        logic [31:0] a;
        a = ($urandom_range(0, 7) == 0) ? ($urandom() | 32'h400) : 32'($urandom_range(0, 31));
        set_port(p, 1'($urandom_range(0, 1)), a, $urandom());
      end
      run_txn($sformatf("rnd%0d", n), mode != 1, mode != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the word-addressed data memory.
- Port 0 is the pipeline MEM stage; port 1 is the debug/loader port, used for test preload and result dump.
- Latches one request at a time, issues exactly one memory cycle for it, captures read data, and returns a one-cycle acknowledge.
- Round-robin arbitration prevents starvation; out-of-range addresses are blocked and flagged.

Parameters:
- DATA_W, 32, data word width.
- ADDR_W, 32, address width; addresses are word indices.
- DEPTH, 1024, number of memory words; valid addresses are 0..DEPTH-1.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0  in  1  port 0 request; held high until ack0.
- we0  in  1  port 0: 1 = write, 0 = read.
- addr0  in  ADDR_W  port 0 word address.
- wdata0  in  DATA_W  port 0 write data.
- ack0  out  1  one-cycle completion pulse for port 0.
- rdata0  out  DATA_W  port 0 read data, valid while ack0 is high.
- err0  out  1  pulses with ack0 when addr0 >= DEPTH.
- stall0  out  1  req0 && !ack0; drives the pipeline stall.
- req1, we1, addr1, wdata1, ack1, rdata1, err1  same as port 0, for port 1.
- mem_read  out  1  memory read enable.
- mem_write  out  1  memory write enable.
- mem_address  out  ADDR_W  memory address.
- mem_write_data  out  DATA_W  memory write data.
- mem_read_data  in  DATA_W  combinational memory read data.

Behaviour:
- States:
  - IDLE: sample requests.
  - ACCESS: drive memory for exactly one cycle.
  - RESP: pulse ack.
- Transitions:
  - IDLE -> ACCESS when req0 | req1.
  - ACCESS -> RESP always.
  - RESP -> IDLE always.
- Latency and throughput:
  - The request is sampled at the IDLE edge; ack is high 2 cycles later, during RESP.
  - Maximum throughput is 1 access per 3 cycles.
- Arbitration (at the IDLE edge):
  - Only one requesting port: grant it.
  - Both requesting: grant the port not granted last (last_grant register).
  - last_grant resets to 1, so port 0 wins the first tie.
  - On grant: latch id, we, addr, wdata into internal registers, and set last_grant = id.
- Range check at latch time: in_range = (addr < DEPTH), compared unsigned across the full ADDR_W.
- ACCESS cycle:
  - mem_address = latched addr; mem_write_data = latched wdata.
  - mem_write = we && in_range; mem_read = !we && in_range.
  - Read data is captured from mem_read_data into rdata_q at the end of the ACCESS cycle.
  - Out of range: no memory enable asserts and rdata_q is 0.
- Outside ACCESS:
  - mem_read = mem_write = 0.
  - mem_address and mem_write_data hold their last latched values.
- RESP cycle:
  - ack of the granted port = 1; rdata of that port = rdata_q (0 for writes).
  - err of that port = !in_range.
  - The other port's ack/err are 0 and its rdata is 0.
  - Requests are ignored during ACCESS and RESP.
- Requester rules:
  - req, we, addr, wdata must stay stable from assertion until the ack cycle.
  - The requester may drop req or present a new request in the cycle after ack.
  - A request still high in IDLE after its ack is treated as a new request.
- stall: stallN = reqN && !ackN, combinational.
- Reset:
  - On rst: state = IDLE, last_grant = 1, latched registers and rdata_q = 0.
  - All ack/err/rdata outputs are 0; mem_address and mem_write_data are 0.
  - mem_read and mem_write are forced 0 while rst is high, even in ACCESS, so no write commits on a reset edge.
  - An aborted access produces no ack; the requester re-requests after reset.

Test Plan:
- Single read: memory holds word 7 at address 7; req0 read addr 7 at cycle 0 -> mem_read=1 in cycle 1, ack0=1 with rdata0=7 in cycle 2, stall0 high in cycles 0-1.
- Write then read: port 1 writes 0xDEADBEEF to addr 12 -> mem_write=1 for exactly one cycle, ack1 pulses; a following port 1 read of addr 12 returns 0xDEADBEEF.
- Contention: req0 and req1 both held continuously -> grant sequence 0,1,0,1; acks alternate every 3 cycles; neither port waits more than 6 cycles.
- Out of range: req0 write to addr 1024, then read of addr 0xFFFFFFFF -> mem_write/mem_read never assert; ack0 with err0=1 and rdata0=0 for both.
- Reset mid-write: assert rst during the ACCESS cycle of a port 1 write to addr 5 -> mem_write=0 in that cycle, addr 5 unchanged, no ack1, all outputs 0 the next cycle.
- Back-to-back: port 0 keeps req0 high with a new address right after ack0, port 1 idle -> second ack0 arrives exactly 3 cycles after the first.
